// File: rtl/gba_bus_arbiter_if.sv
// gba_bus_arbiter_if
//   Bundles the requester-side and memory-side signals of the GBA system-bus
//   arbiter.
//
//   Handshake (req/ack):
//     A requester raises *_req together with addr/we/wdata/lock. It holds them
//     until it sees its one-cycle *_ack. The address and data are captured
//     when the request is granted, so later changes do not affect the
//     transfer in flight. The requester lowers req, or presents its next
//     transfer, in the ack cycle.
//     During a read ack cycle, rdata carries the read data.
//     If lock is high in the ack cycle and req is still high, the same
//     requester keeps the bus for the next transfer.
//
//   Modports:
//     master : the arbiter's view. It takes requests and mem_rdata, and drives
//              the acks, rdata, owner and mem_* signals.
//     slave  : the opposite view (requesters plus memory fabric).
interface gba_bus_arbiter_if #(
  parameter int N_DMA = 4
);
  logic                 cpu_req;
  logic [31:0]          cpu_addr;
  logic                 cpu_we;
  logic [31:0]          cpu_wdata;
  logic                 cpu_lock;
  logic                 cpu_ack;
  logic [N_DMA-1:0]     dma_req;
  logic [32*N_DMA-1:0]  dma_addr;
  logic [N_DMA-1:0]     dma_we;
  logic [32*N_DMA-1:0]  dma_wdata;
  logic [N_DMA-1:0]     dma_lock;
  logic [N_DMA-1:0]     dma_ack;
  logic [31:0]          rdata;
  logic [2:0]           owner;
  logic                 mem_en;
  logic [31:0]          mem_addr;
  logic                 mem_we;
  logic [31:0]          mem_wdata;
  logic [31:0]          mem_rdata;

  modport master (
    input  cpu_req, cpu_addr, cpu_we, cpu_wdata, cpu_lock,
    input  dma_req, dma_addr, dma_we, dma_wdata, dma_lock,
    input  mem_rdata,
    output cpu_ack, dma_ack, rdata, owner,
    output mem_en, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    output cpu_req, cpu_addr, cpu_we, cpu_wdata, cpu_lock,
    output dma_req, dma_addr, dma_we, dma_wdata, dma_lock,
    output mem_rdata,
    input  cpu_ack, dma_ack, rdata, owner,
    input  mem_en, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/gba_bus_arbiter.sv
// gba_bus_arbiter
//   Single-owner arbiter and wait-state sequencer for the GBA system bus.
//
//   Arbitration and timing:
//     - Fixed priority: DMA0 is highest and the CPU is lowest.
//     - One transfer runs at a time.
//     - mem_* outputs are registered.
//     - Wait states depend on the region (addr[27:24]) and on whether the
//       access is N (non-sequential) or S (sequential).
//     - Transfer latency is 2 + wait cycles, from the request edge to the
//       ack cycle.
//
//   Ports:
//     clk        system clock
//     reset      synchronous, active-low
//     bus        gba_bus_arbiter_if.master (requests, acks, rdata, owner, mem_*)
//     fsm_state  current FSM state (0 = IDLE, 1 = ACCESS), for observation
//
//   Optional feature: define GBA_BUS_ARB_STATS_EN to add stall_cpu and
//   stall_dma. These are 32-bit saturating stall counters.
module gba_bus_arbiter #(
  parameter int N_DMA    = 4,
  parameter int WS_EWRAM = 2,
  parameter int WS_ROM_N = 4,
  parameter int WS_ROM_S = 2,
  parameter int WS_W     = 3
) (
  input  logic               clk,
  input  logic               reset,
  gba_bus_arbiter_if.master  bus,
  output logic               fsm_state
`ifdef GBA_BUS_ARB_STATS_EN
  ,
  output logic [31:0]        stall_cpu,
  output logic [31:0]        stall_dma
`endif
);

  localparam logic [2:0] OWNER_CPU = 3'd7;

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t            state, state_next;
  logic [WS_W-1:0]   wcnt;
  logic [2:0]        owner_q;
  logic              cpu_ack_q;
  logic [N_DMA-1:0]  dma_ack_q;
  logic [31:0]       rdata_q;
  logic              mem_en_q;
  logic [31:0]       mem_addr_q;
  logic              mem_we_q;
  logic [31:0]       mem_wdata_q;

  logic              own_req, own_lock, ack_any, keep;
  logic [N_DMA-1:0]  own_onehot;
  logic              win_valid, win_we, win_seq;
  logic [2:0]        win_id;
  logic [31:0]       win_addr, win_wdata;
  logic [WS_W-1:0]   win_ws;

  function automatic logic [WS_W-1:0] ws_for(input logic [3:0] region, input logic seq);
    logic [WS_W-1:0] ws;
    ws = '0;
    if (region == 4'h2)
      ws = WS_W'(WS_EWRAM);
    else if (region >= 4'h8 && region <= 4'hD)
      ws = seq ? WS_W'(WS_ROM_S) : WS_W'(WS_ROM_N);
    return ws;
  endfunction

  assign fsm_state     = state;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.dma_ack   = dma_ack_q;
  assign bus.rdata     = rdata_q;
  assign bus.owner     = owner_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;

  // Request/lock of the current owner. An ack that is still high means the
  // previous transfer finished on the edge just before this IDLE cycle.
  // That is the only point at which a lock can carry ownership over.
  always_comb begin
    own_req    = 1'b0;
    own_lock   = 1'b0;
    own_onehot = '0;
    if (owner_q == OWNER_CPU) begin
      own_req  = bus.cpu_req;
      own_lock = bus.cpu_lock;
    end
    for (int i = 0; i < N_DMA; i++) begin
      if (owner_q == 3'(i)) begin
        own_req       = bus.dma_req[i];
        own_lock      = bus.dma_lock[i];
        own_onehot[i] = 1'b1;
      end
    end
    ack_any = cpu_ack_q | (|dma_ack_q);
    keep    = (state == IDLE) && ack_any && own_req && own_lock;
  end

  // Winner selection: a locked owner first, then the lowest DMA index, then
  // the CPU.
  always_comb begin
    win_valid = 1'b0;
    win_id    = OWNER_CPU;
    if (keep) begin
      win_valid = 1'b1;
      win_id    = owner_q;
    end else if (|bus.dma_req) begin
      win_valid = 1'b1;
      for (int i = N_DMA - 1; i >= 0; i--)
        if (bus.dma_req[i]) win_id = 3'(i);
    end else if (bus.cpu_req) begin
      win_valid = 1'b1;
    end

    win_addr  = bus.cpu_addr;
    win_we    = bus.cpu_we;
    win_wdata = bus.cpu_wdata;
    for (int i = 0; i < N_DMA; i++) begin
      if (win_id == 3'(i)) begin
        win_addr  = bus.dma_addr[32*i +: 32];
        win_we    = bus.dma_we[i];
        win_wdata = bus.dma_wdata[32*i +: 32];
      end
    end

    // mem_addr_q still holds the previous transfer's address. It is only
    // meaningful for S timing when the same owner keeps the bus through a lock.
    win_seq = keep && (win_addr == mem_addr_q + 32'd4);
    win_ws  = ws_for(win_addr[27:24], win_seq);
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (win_valid) state_next = ACCESS;
      ACCESS:  if (wcnt == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wcnt        <= '0;
      owner_q     <= OWNER_CPU;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= '0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      cpu_ack_q <= 1'b0;
      dma_ack_q <= '0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            mem_en_q    <= 1'b1;
            mem_addr_q  <= win_addr;
            mem_we_q    <= win_we;
            mem_wdata_q <= win_wdata;
            owner_q     <= win_id;
            wcnt        <= win_ws;
          end
        end
        ACCESS: begin
          if (wcnt != '0) begin
            wcnt <= wcnt - WS_W'(1);
          end else begin
            rdata_q  <= bus.mem_rdata;
            mem_en_q <= 1'b0;
            if (owner_q == OWNER_CPU) cpu_ack_q <= 1'b1;
            else                      dma_ack_q <= own_onehot;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef GBA_BUS_ARB_STATS_EN
  logic              cpu_served;
  logic [N_DMA-1:0]  dma_served;

  // A requester counts as served only while it owns an ACCESS cycle.
  // IDLE cycles count as stalls for every requester.
  assign cpu_served = (state == ACCESS) && (owner_q == OWNER_CPU);
  assign dma_served = (state == ACCESS) ? own_onehot : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cpu <= '0;
      stall_dma <= '0;
    end else begin
      if (bus.cpu_req && !cpu_served && stall_cpu != '1)
        stall_cpu <= stall_cpu + 32'd1;
      if (|(bus.dma_req & ~dma_served) && stall_dma != '1)
        stall_dma <= stall_dma + 32'd1;
    end
  end
`endif

endmodule
